prog_loader: RTL and testbench
==============================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter NMEM, default 128: instruction-memory depth in 32-bit words.
REQ-002 Parameter AW, default 7: im_addr width; NMEM SHALL be <= 2**AW.
REQ-003 clk  input  1  rising-edge clock; the only clock.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  byte source has a byte on in_data.
REQ-006 in_data  input  8  program stream byte.
REQ-007 in_ready  output  1  loader accepts a byte; transfer occurs when in_valid && in_ready at a rising edge.
REQ-008 restart  input  1  single-cycle pulse; starts a new load from DONE or ERR.
REQ-009 im_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-010 im_addr  output  AW  word address for im_we.
REQ-011 im_wdata  output  32  word for im_we.
REQ-012 cpu_hold  output  1  stalls the cpu (PC and pipeline) while high.
REQ-013 done  output  1  load completed successfully.
REQ-014 err  output  1  load aborted; length exceeds NMEM.

Function
REQ-015 Stream format: 2-byte word count N, MSB first; then 4*N bytes, each word MSB first; word k is written to address k.
REQ-016 States: CNT_HI, CNT_LO, DATA, WRITE, DONE, ERR.
REQ-017 in_ready SHALL be 1 in CNT_HI, CNT_LO, DATA and 0 in WRITE, DONE, ERR; no byte is consumed while in_ready=0.
REQ-018 CNT_HI: on transfer latch N[15:8] -> CNT_LO.
REQ-019 CNT_LO: on transfer latch N[7:0]; full N==0 -> DONE; N>NMEM -> ERR; otherwise -> DATA with word index 0, byte index 0.
REQ-020 DATA: each transfer shifts the byte into a 32-bit assembly register; the 4th byte -> WRITE on the next edge; byte index wraps 3->0.
REQ-021 WRITE lasts exactly one cycle: im_we=1, im_addr=word index, im_wdata=assembled word; then word index +1; -> DONE if the written index was N-1, else -> DATA.
REQ-022 Latency: 4th byte of a word transferred at edge k -> im_we high in the cycle after edge k, written at edge k+1.
REQ-023 im_we SHALL be 0 in every state other than WRITE; im_addr/im_wdata are don't-care when im_we=0.
REQ-024 No inter-byte timeout; in_valid may drop any number of cycles in any accepting state without state change.
REQ-025 cpu_hold SHALL be 1 in every state except DONE; it falls in the first cycle in DONE.
REQ-026 done=1 only in DONE; err=1 only in ERR; both hold until restart or reset.
REQ-027 restart in DONE or ERR -> CNT_HI at next edge, done/err cleared, cpu_hold reasserted the same cycle as state change; restart in any other state is ignored.
REQ-028 Word index counter SHALL be at least AW+1 bits wide; N=NMEM exactly is legal and writes addresses 0..NMEM-1 with no wrap.
REQ-029 Bytes offered after DONE/ERR are not accepted (in_ready=0) until restart.

Reset
REQ-030 Asynchronous reset -> CNT_HI; in_ready=1, im_we=0, im_addr=0, im_wdata=0, cpu_hold=1, done=0, err=0, N=0, indices=0.
REQ-031 Reset asserted mid-load (any state, including during WRITE) SHALL abort immediately with im_we=0 in the same cycle; partially written memory is not cleared.
REQ-032 Reset release SHALL NOT itself cause a byte transfer or write; first transfer possible at the first rising edge after deassertion.

Verification
REQ-033 Stream 00 02 DE AD BE EF 00 00 00 01, in_valid held high -> im_we pulses twice: addr 0 data DEADBEEF, addr 1 data 00000001; done=1, cpu_hold=0 one cycle after the second write; in_ready low during each WRITE.
REQ-034 Stream 00 00 -> DONE directly after the 2nd byte, no im_we pulse, cpu_hold drops.
REQ-035 With NMEM=128, stream 00 81 -> err=1, cpu_hold=1, in_ready=0, no writes; restart then 00 01 12 34 56 78 -> addr 0 data 12345678, done=1.
REQ-036 N=128 (00 80) with 512 random bytes and random in_valid gaps -> exactly 128 writes, addresses 0..127 in order, data matching a reference model.
REQ-037 Reset pulsed after the 3rd data byte of word 1 -> im_we stays 0, state CNT_HI, cpu_hold=1; fresh stream 00 01 AA BB CC DD loads addr 0 = AABBCCDD.
REQ-038 restart pulsed during DATA -> ignored; load continues and completes unchanged.

Source files
------------

// File: rtl/prog_loader.sv
// Boot-time program loader: turns a byte stream into
// instruction-memory writes and holds the cpu until done.
module prog_loader #(
  parameter int NMEM = 128,
  parameter int AW   = 7
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  input  logic          restart,
  output logic          im_we,
  output logic [AW-1:0] im_addr,
  output logic [31:0]   im_wdata,
  output logic          cpu_hold,
  output logic          done,
  output logic          err
);

  typedef enum logic [2:0] {
    CNT_HI,
    CNT_LO,
    DATA,
    WRITE,
    DONE,
    ERR
  } state_t;

  localparam logic [15:0] NMAX = 16'(NMEM);

  state_t      state;
  state_t      nxt;
  logic [15:0] cnt;
  logic [AW:0] widx;
  logic [1:0]  bidx;
  logic [31:0] asmw;
  logic        xfer;
  logic [15:0] n_full;
  logic        last;

  assign xfer     = in_valid && in_ready;
  assign n_full   = {cnt[15:8], in_data};
  assign last     = (16'(widx) + 16'd1) == cnt;
  assign im_addr  = widx[AW-1:0];
  assign im_wdata = asmw;

  // State register; reset aborts any load at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= CNT_HI;
    else       state <= nxt;
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    nxt      = state;
    in_ready = 1'b0;
    im_we    = 1'b0;
    cpu_hold = 1'b1;
    done     = 1'b0;
    err      = 1'b0;
    unique case (state)
      CNT_HI: begin
        in_ready = 1'b1;
        if (xfer) nxt = CNT_LO;
      end
      CNT_LO: begin
        in_ready = 1'b1;
        if (xfer) begin
          if (n_full == 16'd0)  nxt = DONE;
          else if (n_full > NMAX) nxt = ERR;
          else                  nxt = DATA;
        end
      end
      DATA: begin
        in_ready = 1'b1;
        if (xfer && bidx == 2'd3) nxt = WRITE;
      end
      WRITE: begin
        im_we = 1'b1;
        nxt   = last ? DONE : DATA;
      end
      DONE: begin
        cpu_hold = 1'b0;
        done     = 1'b1;
        if (restart) nxt = CNT_HI;
      end
      ERR: begin
        err = 1'b1;
        if (restart) nxt = CNT_HI;
      end
      default: nxt = CNT_HI;
    endcase
  end

  // Count, word/byte indices and word assembly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      widx <= '0;
      bidx <= '0;
      asmw <= '0;
    end else begin
      unique case (state)
        CNT_HI: if (xfer) cnt[15:8] <= in_data;
        CNT_LO: begin
          if (xfer) begin
            cnt[7:0] <= in_data;
            widx     <= '0;
            bidx     <= '0;
          end
        end
        DATA: begin
          if (xfer) begin
            asmw <= {asmw[23:0], in_data};
            bidx <= bidx + 2'd1;
          end
        end
        WRITE: widx <= widx + 1'b1;
        DONE, ERR: begin
          if (restart) begin
            cnt  <= '0;
            widx <= '0;
            bidx <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: writes are
// predicted on issue and checked by a monitor.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        restart;
  logic        im_we;
  logic [6:0]  im_addr;
  logic [31:0] im_wdata;
  logic        cpu_hold;
  logic        done;
  logic        err;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [6:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t q[$];

  prog_loader #(.NMEM(128), .AW(7)) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .restart(restart),
    .im_we(im_we),
    .im_addr(im_addr),
    .im_wdata(im_wdata),
    .cpu_hold(cpu_hold),
    .done(done),
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Monitor: every write must match the oldest prediction.
  always @(negedge clk) begin
    if (!reset && im_we) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_write: got a=%0d d=%h want none",
                 im_addr, im_wdata);
      end else begin
        wr_t e;
        e = q.pop_front();
        if (im_addr !== e.a || im_wdata !== e.d) begin
          fails++;
          $display("FAIL write: got a=%0d d=%h want a=%0d d=%h",
                   im_addr, im_wdata, e.a, e.d);
        end
      end
      chk("in_ready_in_write", 32'(in_ready), 32'd0);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 100) begin
      tick(1);
      n++;
    end
    if (n >= 100) chk("send_timeout", 32'(n), 32'd0);
    tick(1);
    in_valid = 1'b0;
  endtask

  task automatic send_cnt(input logic [15:0] n);
    send(n[15:8]);
    send(n[7:0]);
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int i = 3; i >= 0; i--) begin
      send(w[i*8 +: 8]);
      if (gap > 0) tick($urandom_range(0, gap));
    end
  endtask

  task automatic expect_wr(input int a, input logic [31:0] d);
    wr_t e;
    e.a = 7'(a);
    e.d = d;
    q.push_back(e);
  endtask

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    while (!done && n < 50) begin
      tick(1);
      n++;
    end
    chk(nm, 32'(done), 32'd1);
  endtask

  task automatic pulse_restart;
    restart = 1'b1;
    tick(1);
    restart = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    restart  = 1'b0;
    tick(2);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_im_we", 32'(im_we), 32'd0);
    chk("rst_im_addr", 32'(im_addr), 32'd0);
    chk("rst_im_wdata", im_wdata, 32'd0);
    chk("rst_cpu_hold", 32'(cpu_hold), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    reset = 1'b0;
    tick(1);

    // Two-word stream, in_valid held high.
    expect_wr(0, 32'hDEADBEEF);
    expect_wr(1, 32'h00000001);
    send_cnt(16'd2);
    send_word(32'hDEADBEEF, 0);
    chk("w0_we_next_cycle", 32'(im_we), 32'd1);
    send_word(32'h00000001, 0);
    chk("w1_we_next_cycle", 32'(im_we), 32'd1);
    chk("w1_hold_in_write", 32'(cpu_hold), 32'd1);
    tick(1);
    chk("two_done", 32'(done), 32'd1);
    chk("two_hold_low", 32'(cpu_hold), 32'd0);
    chk("two_in_ready_low", 32'(in_ready), 32'd0);
    chk("two_q_empty", 32'(q.size()), 32'd0);

    // Bytes offered in DONE are not taken.
    in_valid = 1'b1;
    in_data  = 8'h55;
    tick(3);
    in_valid = 1'b0;
    chk("done_stays", 32'(done), 32'd1);

    // Zero-length program.
    pulse_restart();
    chk("restart_hold", 32'(cpu_hold), 32'd1);
    chk("restart_done_clr", 32'(done), 32'd0);
    send_cnt(16'd0);
    chk("zero_done", 32'(done), 32'd1);
    chk("zero_hold", 32'(cpu_hold), 32'd0);

    // Length one over capacity.
    pulse_restart();
    send_cnt(16'h0081);
    chk("ovf_err", 32'(err), 32'd1);
    chk("ovf_hold", 32'(cpu_hold), 32'd1);
    chk("ovf_in_ready", 32'(in_ready), 32'd0);
    chk("ovf_done", 32'(done), 32'd0);
    in_valid = 1'b1;
    tick(3);
    in_valid = 1'b0;
    chk("ovf_err_holds", 32'(err), 32'd1);
    pulse_restart();
    chk("ovf_err_clr", 32'(err), 32'd0);
    chk("ovf_ready_again", 32'(in_ready), 32'd1);
    expect_wr(0, 32'h12345678);
    send_cnt(16'd1);
    send_word(32'h12345678, 0);
    wait_done("ovf_recover_done");

    // Full depth with random data and gaps.
    pulse_restart();
    send_cnt(16'd128);
    for (int k = 0; k < 128; k++) begin
      logic [31:0] w;
      w = $urandom;
      expect_wr(k, w);
      send_word(w, 2);
    end
    wait_done("full_done");
    chk("full_q_empty", 32'(q.size()), 32'd0);

    // Reset after 3rd byte of word 1.
    pulse_restart();
    expect_wr(0, 32'h01020304);
    send_cnt(16'd2);
    send_word(32'h01020304, 0);
    send(8'hA1);
    send(8'hA2);
    send(8'hA3);
    reset = 1'b1;
    #1;
    chk("mid_rst_we", 32'(im_we), 32'd0);
    chk("mid_rst_hold", 32'(cpu_hold), 32'd1);
    chk("mid_rst_ready", 32'(in_ready), 32'd1);
    tick(1);
    reset = 1'b0;
    tick(1);
    chk("mid_rst_q_empty", 32'(q.size()), 32'd0);
    expect_wr(0, 32'hAABBCCDD);
    send_cnt(16'd1);
    send_word(32'hAABBCCDD, 0);
    wait_done("mid_rst_reload");

    // Reset landing in the WRITE cycle.
    pulse_restart();
    send_cnt(16'd1);
    send_word(32'h11223344, 0);
    chk("wr_rst_pre_we", 32'(im_we), 32'd1);
    reset = 1'b1;
    #1;
    chk("wr_rst_we", 32'(im_we), 32'd0);
    tick(1);
    reset = 1'b0;
    tick(1);
    chk("wr_rst_done", 32'(done), 32'd0);

    // Restart in DATA is ignored.
    expect_wr(0, 32'hCAFEF00D);
    expect_wr(1, 32'h0BADC0DE);
    send_cnt(16'd2);
    send(8'hCA);
    send(8'hFE);
    pulse_restart();
    chk("rs_data_ready", 32'(in_ready), 32'd1);
    send(8'hF0);
    send(8'h0D);
    send_word(32'h0BADC0DE, 1);
    wait_done("rs_data_done");
    chk("rs_q_empty", 32'(q.size()), 32'd0);

    tick(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
